// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read / 1-write register file.
package regfile_pkg;

    // Default geometry of the register array.
    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 3;
    localparam int NBYTES       = RF_DATA_W / 8;
    localparam int DEPTH        = 2 ** RF_ADDR_W;

    // Widest byte-enable vector byte_mask() can expand.
    localparam int RF_MAX_BYTES = 32;
    localparam int RF_MAX_W     = RF_MAX_BYTES * 8;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    // Expand a byte-enable vector into a bit mask, one byte of ones per set enable.
    // Callers zero-extend their enables and keep the low DATA_W bits of the result.
    function automatic logic [RF_MAX_W-1:0] byte_mask(input logic [RF_MAX_BYTES-1:0] be);
        logic [RF_MAX_W-1:0] m;
        for (int i = 0; i < RF_MAX_BYTES; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/register_file_2r1w_read_port.sv
// One combinational read path: array select, optional write bypass, optional zero register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] w_mask,
    output logic [DATA_W-1:0] r_data
);

    // Stored value, overlaid by the in-flight write when bypassing; entry 0 forced last so it wins.
    always_comb begin
        r_data = mem[r_addr];
        if ((BYPASS != 0) && byp_en && (r_addr == w_addr)) begin
            r_data = (w_data & w_mask) | (mem[r_addr] & ~w_mask);
        end
        if ((ZERO_REG != 0) && (r_addr == '0)) begin
            r_data = '0;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// General-purpose register array: byte-enabled write port, two combinational read
// ports, and a sequenced bulk-clear engine that zeroes one entry per cycle.
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wAddr,
    input  logic [DATA_W-1:0]   wData,
    input  logic [DATA_W/8-1:0] wBe,
    input  logic [ADDR_W-1:0]   rAddr0,
    output logic [DATA_W-1:0]   rData0,
    input  logic [ADDR_W-1:0]   rAddr1,
    output logic [DATA_W-1:0]   rData1,
    input  logic                clr,
    output logic                busy
);

    localparam int                BE_W      = DATA_W / 8;
    localparam int                ENTRIES   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    rf_state_t                 state_q, state_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]         mem_q [ENTRIES];
    logic [DATA_W-1:0]         mem_d [ENTRIES];

    logic [RF_MAX_BYTES-1:0]   be_full;
    logic [RF_MAX_W-1:0]       mask_full;
    logic [DATA_W-1:0]         w_mask;
    logic                      idle_write;
    logic                      write_ok;

    // Expand the byte enables into a DATA_W-wide merge mask.
    always_comb begin
        be_full           = '0;
        be_full[BE_W-1:0] = wBe;
        mask_full         = byte_mask(be_full);
        w_mask            = mask_full[DATA_W-1:0];
    end

    if (DATA_W < RF_MAX_W) begin : g_mask_hi
        logic unused_mask_hi;
        assign unused_mask_hi = ^mask_full[RF_MAX_W-1:DATA_W];
    end

    // Writes (and bypass) only exist while idle; entry 0 is read-only when hardwired to zero.
    always_comb begin
        idle_write = we && (state_q == RF_IDLE);
        write_ok   = idle_write && !((ZERO_REG != 0) && (wAddr == '0));
    end

    // Clear sequencer: walk the counter from 0 to the last entry, then drop back to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (clr) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next array contents: clearing owns the array; otherwise merge the enabled write bytes.
    always_comb begin
        mem_d = mem_q;
        if (state_q == RF_CLEAR) begin
            mem_d[cnt_q] = '0;
        end else if (write_ok) begin
            mem_d[wAddr] = (wData & w_mask) | (mem_q[wAddr] & ~w_mask);
        end
    end

    // State, counter and storage registers; reset empties the whole array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign busy = (state_q == RF_CLEAR);

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_read0 (
        .mem    (mem_q),
        .r_addr (rAddr0),
        .byp_en (idle_write),
        .w_addr (wAddr),
        .w_data (wData),
        .w_mask (w_mask),
        .r_data (rData0)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_read1 (
        .mem    (mem_q),
        .r_addr (rAddr1),
        .byp_en (idle_write),
        .w_addr (wAddr),
        .w_data (wData),
        .w_mask (w_mask),
        .r_data (rData1)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: three instances share stimulus -- bypass on,
// bypass off, and hardwired zero register -- so each option can be observed.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  wBe;
    logic [2:0]  rAddr0;
    logic [2:0]  rAddr1;
    logic        clr;

    logic [31:0] rd0_b, rd1_b, rd0_n, rd1_n, rd0_z, rd1_z;
    logic        busy_b, busy_n, busy_z;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    register_file_2r1w #(.DATA_W(32), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .rAddr0(rAddr0), .rData0(rd0_b), .rAddr1(rAddr1), .rData1(rd1_b),
        .clr(clr), .busy(busy_b)
    );

    register_file_2r1w #(.DATA_W(32), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .rAddr0(rAddr0), .rData0(rd0_n), .rAddr1(rAddr1), .rData1(rd1_n),
        .clr(clr), .busy(busy_n)
    );

    register_file_2r1w #(.DATA_W(32), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .rAddr0(rAddr0), .rData0(rd0_z), .rAddr1(rAddr1), .rData1(rd1_z),
        .clr(clr), .busy(busy_z)
    );

    // Drive one write between falling edges so it commits on the next rising edge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        we    = 1'b1;
        wAddr = a;
        wData = d;
        wBe   = be;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wBe   = 4'h0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        we     = 1'b0;
        clr    = 1'b0;
        wAddr  = 3'd0;
        wData  = 32'h0;
        wBe    = 4'h0;
        rAddr0 = 3'd0;
        rAddr1 = 3'd5;
        #3;
        tests_run++;
        if (rd0_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rd0: got %h expected %h", rd0_b, 32'h0);
        end
        tests_run++;
        if (rd1_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rd1: got %h expected %h", rd1_b, 32'h0);
        end
        tests_run++;
        if (busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy_b);
        end
        #4;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        do_write(3'd0, 32'h1111_1111, 4'hF);
        do_write(3'd1, 32'hff00_ff00, 4'hF);
        rAddr0 = 3'd0;
        rAddr1 = 3'd1;
        #1;
        tests_run++;
        if (rd0_b !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL wr_rd_port0: got %h expected %h", rd0_b, 32'h1111_1111);
        end
        tests_run++;
        if (rd1_b !== 32'hff00_ff00) begin
            tests_failed++;
            $display("FAIL wr_rd_port1: got %h expected %h", rd1_b, 32'hff00_ff00);
        end
        tests_run++;
        if (rd1_n !== 32'hff00_ff00) begin
            tests_failed++;
            $display("FAIL wr_rd_nobyp: got %h expected %h", rd1_n, 32'hff00_ff00);
        end
        rAddr1 = 3'd0;
        #1;
        tests_run++;
        if (rd1_b !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL wr_rd_same_addr: got %h expected %h", rd1_b, 32'h1111_1111);
        end
    endtask

    task automatic test_byte_enable();
        do_write(3'd2, 32'hff00_ff00, 4'hF);
        do_write(3'd2, 32'h1234_5678, 4'b0101);
        rAddr0 = 3'd2;
        #1;
        tests_run++;
        if (rd0_b !== 32'hff34_ff78) begin
            tests_failed++;
            $display("FAIL byte_en: got %h expected %h", rd0_b, 32'hff34_ff78);
        end
        do_write(3'd2, 32'hcccc_cccc, 4'h0);
        #1;
        tests_run++;
        if (rd0_b !== 32'hff34_ff78) begin
            tests_failed++;
            $display("FAIL byte_en_none: got %h expected %h", rd0_b, 32'hff34_ff78);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we     = 1'b1;
        wAddr  = 3'd3;
        wData  = 32'h00ff_00ff;
        wBe    = 4'hF;
        rAddr0 = 3'd3;
        #1;
        tests_run++;
        if (rd0_b !== 32'h00ff_00ff) begin
            tests_failed++;
            $display("FAIL bypass_on: got %h expected %h", rd0_b, 32'h00ff_00ff);
        end
        tests_run++;
        if (rd0_n !== 32'h0) begin
            tests_failed++;
            $display("FAIL bypass_off_pre: got %h expected %h", rd0_n, 32'h0);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        tests_run++;
        if (rd0_n !== 32'h00ff_00ff) begin
            tests_failed++;
            $display("FAIL bypass_off_post: got %h expected %h", rd0_n, 32'h00ff_00ff);
        end
        // Partial-byte bypass on port 1 merges with the stored value.
        @(negedge clk);
        we     = 1'b1;
        wAddr  = 3'd2;
        wData  = 32'haaaa_aaaa;
        wBe    = 4'b0011;
        rAddr1 = 3'd2;
        #1;
        tests_run++;
        if (rd1_b !== 32'hff34_aaaa) begin
            tests_failed++;
            $display("FAIL bypass_partial: got %h expected %h", rd1_b, 32'hff34_aaaa);
        end
        tests_run++;
        if (rd1_n !== 32'hff34_ff78) begin
            tests_failed++;
            $display("FAIL bypass_partial_off: got %h expected %h", rd1_n, 32'hff34_ff78);
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        wBe = 4'h0;
        tests_run++;
        if (rd1_n !== 32'hff34_aaaa) begin
            tests_failed++;
            $display("FAIL bypass_partial_commit: got %h expected %h", rd1_n, 32'hff34_aaaa);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we     = 1'b1;
        wAddr  = 3'd0;
        wData  = 32'hdead_beef;
        wBe    = 4'hF;
        rAddr0 = 3'd0;
        rAddr1 = 3'd0;
        #1;
        tests_run++;
        if (rd0_z !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_byp0: got %h expected %h", rd0_z, 32'h0);
        end
        tests_run++;
        if (rd1_z !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_byp1: got %h expected %h", rd1_z, 32'h0);
        end
        tests_run++;
        if (rd0_b !== 32'hdead_beef) begin
            tests_failed++;
            $display("FAIL zero_reg_off_byp: got %h expected %h", rd0_b, 32'hdead_beef);
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        wBe = 4'h0;
        tests_run++;
        if (rd0_z !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_post0: got %h expected %h", rd0_z, 32'h0);
        end
        tests_run++;
        if (rd1_z !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_post1: got %h expected %h", rd1_z, 32'h0);
        end
        tests_run++;
        if (rd0_n !== 32'hdead_beef) begin
            tests_failed++;
            $display("FAIL zero_reg_off_store: got %h expected %h", rd0_n, 32'hdead_beef);
        end
    endtask

    task automatic test_bulk_clear();
        int   busy_cnt;
        logic busy_first;
        busy_cnt   = 0;
        busy_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 32'h0101_0101 * 32'(i + 1), 4'hF);
        end
        rAddr0 = 3'd7;
        #1;
        tests_run++;
        if (rd0_b !== 32'h0808_0808) begin
            tests_failed++;
            $display("FAIL clear_fill: got %h expected %h", rd0_b, 32'h0808_0808);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy_b === 1'b1) busy_cnt++;
            if (c == 0) busy_first = busy_b;
            if (c == 2) clr = 1'b1;
            if (c == 3) clr = 1'b0;
            if (c == 6) begin
                we     = 1'b1;
                wAddr  = 3'd5;
                wData  = 32'haaaa_aaaa;
                wBe    = 4'hF;
                rAddr0 = 3'd5;
                #1;
                tests_run++;
                if (rd0_b !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL clear_no_bypass: got %h expected %h", rd0_b, 32'h0);
                end
            end
            if (c == 7) begin
                we  = 1'b0;
                wBe = 4'h0;
            end
        end
        tests_run++;
        if (busy_first !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_busy_start: got %b expected 1", busy_first);
        end
        tests_run++;
        if (busy_cnt != 8) begin
            tests_failed++;
            $display("FAIL clear_busy_cycles: got %0d expected 8", busy_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            rAddr0 = 3'(i);
            rAddr1 = 3'(i);
            #1;
            tests_run++;
            if (rd0_b !== 32'h0) begin
                tests_failed++;
                $display("FAIL clear_entry%0d: got %h expected %h", i, rd0_b, 32'h0);
            end
            tests_run++;
            if (rd1_n !== 32'h0) begin
                tests_failed++;
                $display("FAIL clear_entry%0d_nobyp: got %h expected %h", i, rd1_n, 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(3'd4, 32'h4444_4444, 4'hF);
        do_write(3'd7, 32'h7777_7777, 4'hF);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        rAddr0 = 3'd7;
        rAddr1 = 3'd4;
        #1;
        tests_run++;
        if (busy_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL midclr_busy_pre: got %b expected 1", busy_b);
        end
        tests_run++;
        if (rd0_b !== 32'h7777_7777) begin
            tests_failed++;
            $display("FAIL midclr_partial: got %h expected %h", rd0_b, 32'h7777_7777);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL midclr_busy_rst: got %b expected 0", busy_b);
        end
        tests_run++;
        if (rd0_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL midclr_entry7: got %h expected %h", rd0_b, 32'h0);
        end
        tests_run++;
        if (rd1_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL midclr_entry4: got %h expected %h", rd1_b, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        do_write(3'd6, 32'h6666_6666, 4'hF);
        rAddr0 = 3'd6;
        #1;
        tests_run++;
        if (rd0_b !== 32'h6666_6666) begin
            tests_failed++;
            $display("FAIL midclr_post_write: got %h expected %h", rd0_b, 32'h6666_6666);
        end
        tests_run++;
        if (busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL midclr_post_busy: got %b expected 0", busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_bypass();
        test_zero_reg();
        test_bulk_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
Parametrised successor of the 8x32 single-read register file. Provides one byte-enabled write port and two independent combinational read ports. An optional write-to-read bypass and an optional hardwired-zero register 0 are selectable by parameter. A sequenced bulk-clear engine zeroes the array one entry per cycle. The block sits in the datapath as the general-purpose register array feeding ALU and shifter operands.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
BYPASS, 1, 1 = a read of the address being written this cycle returns the merged write data; 0 = the read returns the stored value.
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes and bypass.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
we  input  1  write enable.
wAddr  input  ADDR_W  write address.
wData  input  DATA_W  write data.
wBe  input  DATA_W/8  byte enables; bit i covers wData[8i+7:8i].
rAddr0  input  ADDR_W  read address, port 0.
rData0  output  DATA_W  read data, port 0; combinational.
rAddr1  input  ADDR_W  read address, port 1.
rData1  output  DATA_W  read data, port 1; combinational.
clr  input  1  bulk-clear request; single-cycle pulse or level.
busy  output  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-high, named `reset`.
- Reset: every entry goes to 0, FSM to IDLE, clear counter to 0, busy=0. rData0/rData1 then reflect zeros.
- Write: at a rising edge with we=1 and state IDLE, entry[wAddr] byte i takes wData byte i where wBe[i]=1. Other bytes are unchanged. wBe=0 is a no-op.
- Read: rDataN = entry[rAddrN], combinational, 0-cycle latency.
- Both ports may read the same address; each port is independent.
- Bypass (BYPASS=1): if we=1, state IDLE and rAddrN==wAddr, rDataN = (wData & byte mask) | (entry & ~byte mask) in the same cycle.
- ZERO_REG=1: reads of address 0 return 0, including under bypass. Writes to address 0 are discarded.
- FSM states:
  - IDLE: clr=1 at an edge -> CLEAR; counter=0, busy=1 from the next cycle.
  - CLEAR: each edge zeroes entry[counter] and increments counter. When counter==DEPTH-1, the entry is zeroed, FSM returns to IDLE, busy=0 next cycle. The clear takes exactly DEPTH cycles.
- Simultaneous we and clr in IDLE: the write commits at that edge, then the clear begins, so the entry is zeroed later.
- During CLEAR: we is ignored, with no array update and no bypass. clr is ignored, with no restart. Reads return current contents; partially cleared contents are legal.
- Counter wrap: the counter is ADDR_W bits. It is never observed past DEPTH-1 because of the exit at DEPTH-1.
- Reset mid-clear: immediate return to IDLE with all entries 0 and busy=0.
- X-free: no output depends on uninitialised state after reset.

Decomposition:
- Shared package `regfile_pkg`:
  - state enum `rf_state_t` {RF_IDLE, RF_CLEAR};
  - function `byte_mask(be)` expanding wBe to a DATA_W mask;
  - localparam helpers NBYTES = DATA_W/8 and DEPTH.
- Sub-module `regfile_read_port` covers one read path: array select, bypass mux, zero-reg override. It is instantiated twice.
- The top holds the storage array, the write logic and the clear FSM.

Test Plan:
1. Reset-then-write/read: assert reset for 7 ns. Write 0x1111_1111 to addr 0 and 0xff00_ff00 to addr 1, wBe=4'hF. Then rAddr0=0 and rAddr1=1 -> rData0=0x1111_1111, rData1=0xff00_ff00.
2. Byte enables: addr 2 holds 0xff00_ff00. Write 0x1234_5678 with wBe=4'b0101 -> addr 2 reads 0xff34_ff78.
3. Bypass: BYPASS=1, addr 3 holds 0. In the same cycle, we=1, wAddr=3, wData=0x00ff_00ff, rAddr0=3 -> rData0=0x00ff_00ff before the edge. With BYPASS=0 -> rData0=0 until after the edge.
4. Zero register: ZERO_REG=1. Write 0xdead_beef to addr 0 -> rData0 and rData1 at addr 0 = 0, including in the write cycle.
5. Bulk clear: fill all 8 entries with nonzero values and pulse clr. busy is high for exactly 8 cycles. A write of 0xaaaa_aaaa to addr 5 during busy is dropped, and a second clr is ignored. After busy falls, all entries read 0.
6. Reset mid-clear: assert reset 3 cycles into the clear -> busy=0 immediately and all entries 0. A write after reset release commits normally.
